// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the buffered transmitter.
package uart_pkg;

  // Level driven on an idle serial line
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Whole sysclk cycles per bit period; the remainder is discarded
  function automatic int baud_ticks(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a sticky overflow flag.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [LW-1:0]    w_count_n;

  // A write is judged against the full flag before the edge, so a pop never
  // frees room for a write in the same cycle.
  assign w_wr_en = i_wr & ~r_full;
  assign w_rd_en = i_rd & ~r_empty;

  // Next occupancy, shared by the count and the full/empty flags
  always_comb begin
    w_count_n = r_count;
    if (w_wr_en && !w_rd_en) begin
      w_count_n = r_count + 1'b1;
    end else if (!w_wr_en && w_rd_en) begin
      w_count_n = r_count - 1'b1;
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_n;
      r_full  <= (w_count_n == LW'(DEPTH));
      r_empty <= (w_count_n == '0);
      if (i_wr && r_full) r_overflow <= 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser with back-to-back frames.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int DEPTH           = 16
) (
  input  logic                   sysclk,
  input  logic                   rst_in,
  input  logic [DATA_BITS-1:0]   data_in,
  input  logic                   write_in,
  output logic                   full_out,
  output logic                   empty_out,
  output logic [$clog2(DEPTH):0] level_out,
  output logic                   overflow_out,
  output logic                   tx_serial_out,
  output logic                   tx_busy_out,
  output logic                   tx_done_out
);

  localparam int BAUD_TICKS = baud_ticks(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W      = $clog2(BAUD_TICKS + 1);
  localparam int BIT_W      = $clog2(DATA_BITS + 1);

  tx_state_t              r_state;
  logic [CNT_W-1:0]       r_baud_cnt;
  logic [BIT_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx;
  logic                   r_done;

  tx_state_t              w_state_n;
  logic [CNT_W-1:0]       w_baud_cnt_n;
  logic [BIT_W-1:0]       w_bit_idx_n;
  logic [DATA_BITS-1:0]   w_shift_n;
  logic                   w_tx_n;
  logic                   w_done_n;
  logic                   w_pop;
  logic                   w_bit_end;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk        (sysclk),
    .rst        (rst_in),
    .i_wr       (write_in),
    .i_data     (data_in),
    .i_rd       (w_pop),
    .o_data     (w_head),
    .o_full     (full_out),
    .o_empty    (w_empty),
    .o_level    (level_out),
    .o_overflow (overflow_out)
  );

  assign w_bit_end = (r_baud_cnt == CNT_W'(BAUD_TICKS - 1));

  // Next-state, line level, FIFO pop and done pulse for the serialiser
  always_comb begin
    w_state_n    = r_state;
    w_baud_cnt_n = r_baud_cnt + 1'b1;
    w_bit_idx_n  = r_bit_idx;
    w_shift_n    = r_shift;
    w_tx_n       = r_tx;
    w_done_n     = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_cnt_n = '0;
        w_tx_n       = UART_IDLE_LEVEL;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_tx_n    = ~UART_IDLE_LEVEL;
          w_state_n = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_cnt_n = '0;
          w_bit_idx_n  = '0;
          w_tx_n       = r_shift[0];
          w_state_n    = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_n = '0;
          if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
            w_tx_n    = UART_IDLE_LEVEL;
            w_state_n = STOP;
          end else begin
            w_shift_n   = r_shift >> 1;
            w_tx_n      = r_shift[1];
            w_bit_idx_n = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_n = '0;
          w_done_n     = 1'b1;
          // Chain straight into the next frame when more data is queued
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_tx_n    = ~UART_IDLE_LEVEL;
            w_state_n = START;
          end else begin
            w_tx_n    = UART_IDLE_LEVEL;
            w_state_n = IDLE;
          end
        end
      end
      default: begin
        w_baud_cnt_n = '0;
        w_tx_n       = UART_IDLE_LEVEL;
        w_state_n    = IDLE;
      end
    endcase
  end

  // Serialiser state register; reset forces the line idle without waiting for a clock
  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_tx       <= UART_IDLE_LEVEL;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_baud_cnt <= w_baud_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_tx       <= w_tx_n;
      r_done     <= w_done_n;
    end
  end

  // Payload shift register; its content is only observed after a pop loads it
  always_ff @(posedge sysclk) begin
    r_shift <= w_shift_n;
  end

  assign empty_out     = w_empty;
  assign tx_serial_out = r_tx;
  assign tx_busy_out   = (r_state != IDLE);
  assign tx_done_out   = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with a serial-line scoreboard.
module tb_uart_tx_buffered;

  localparam int CLK_F = 8_000_000;
  localparam int BAUD  = 1_000_000;
  localparam int T     = CLK_F / BAUD;   // 8 cycles per bit
  localparam int FRAME = 10 * T;         // 80 cycles per frame
  localparam int DEPTH = 16;

  logic       sysclk = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = '0;
  logic       write_in = 1'b0;
  logic       full_out, empty_out, overflow_out;
  logic [4:0] level_out;
  logic       tx_serial_out, tx_busy_out, tx_done_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         done_q[$];
  int         start_q[$];
  int         rx_count = 0;

  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  uart_tx_buffered #(
    .CLOCK_FREQUENCY (CLK_F),
    .BAUD_RATE       (BAUD),
    .DATA_BITS       (8),
    .DEPTH           (DEPTH)
  ) dut (
    .sysclk        (sysclk),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .write_in      (write_in),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .level_out     (level_out),
    .overflow_out  (overflow_out),
    .tx_serial_out (tx_serial_out),
    .tx_busy_out   (tx_busy_out),
    .tx_done_out   (tx_done_out)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Record done pulses by cycle number
  always @(negedge sysclk) begin
    if (!rst_in && tx_done_out) done_q.push_back(cyc);
  end

  // Serial receiver: sample each bit mid-period, compare frames against the scoreboard
  always @(negedge sysclk) begin
    if (rst_in) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx_serial_out == 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % T == T / 2) begin
        int k;
        k = mon_cnt / T;
        if (k == 0) begin
          checks++;
          if (tx_serial_out !== 1'b0) begin
            failures++;
            $display("FAIL start_bit actual=%b expected=0", tx_serial_out);
          end
        end else if (k <= 8) begin
          mon_byte[k-1] = tx_serial_out;
        end else begin
          checks++;
          if (tx_serial_out !== 1'b1) begin
            failures++;
            $display("FAIL stop_bit actual=%b expected=1", tx_serial_out);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected actual=%h expected=none", mon_byte);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (mon_byte !== e) begin
              failures++;
              $display("FAIL frame_data actual=%h expected=%h", mon_byte, e);
            end
          end
          rx_count++;
          mon_active = 0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    data_in = d;
    write_in = 1'b1;
    @(posedge sysclk);
    #1;
    write_in = 1'b0;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy_out || !tx_serial_out) && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain_timeout actual=%0d_pending expected=0_pending", name, exp_q.size());
    end
    checks++;
    if (level_out !== 5'd0 || empty_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_drain_level actual=%0d/%b expected=0/1", name, level_out, empty_out);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    step(3);
    checks++; if (tx_serial_out !== 1'b1) begin failures++; $display("FAIL rst_line actual=%b expected=1", tx_serial_out); end
    checks++; if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b expected=0", tx_busy_out); end
    checks++; if (tx_done_out !== 1'b0) begin failures++; $display("FAIL rst_done actual=%b expected=0", tx_done_out); end
    checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL rst_overflow actual=%b expected=0", overflow_out); end
    checks++; if (level_out !== 5'd0) begin failures++; $display("FAIL rst_level actual=%0d expected=0", level_out); end
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL rst_empty actual=%b expected=1", empty_out); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL rst_full actual=%b expected=0", full_out); end
    rst_in = 1'b0;
    step(3);
  endtask

  task automatic test_single;
    int k0, n;
    done_q.delete();
    start_q.delete();
    k0 = cyc;
    wr(8'hA5, 1);
    checks++; if (empty_out !== 1'b0) begin failures++; $display("FAIL single_empty_fall actual=%b expected=0", empty_out); end
    checks++; if (tx_serial_out !== 1'b1) begin failures++; $display("FAIL single_line_early actual=%b expected=1", tx_serial_out); end
    step(1);
    checks++; if (tx_serial_out !== 1'b0) begin failures++; $display("FAIL single_start_edge actual=%b expected=0", tx_serial_out); end
    checks++; if (tx_busy_out !== 1'b1) begin failures++; $display("FAIL single_busy actual=%b expected=1", tx_busy_out); end
    n = 0;
    while (tx_done_out !== 1'b1 && n < 3 * FRAME) begin step(1); n++; end
    checks++;
    if (cyc != k0 + 2 + FRAME) begin
      failures++;
      $display("FAIL single_done_time actual=%0d expected=%0d", cyc, k0 + 2 + FRAME);
    end
    checks++; if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL single_busy_fall actual=%b expected=0", tx_busy_out); end
    step(1);
    checks++; if (tx_done_out !== 1'b0) begin failures++; $display("FAIL single_done_width actual=%b expected=0", tx_done_out); end
    wait_drain("single", 2 * FRAME);
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL single_done_count actual=%0d expected=1", done_q.size()); end
  endtask

  task automatic test_back_to_back;
    int n;
    done_q.delete();
    start_q.delete();
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    n = 0;
    while (done_q.size() < 3 && n < 5 * FRAME) begin step(1); n++; end
    checks++;
    if (done_q.size() < 3 || start_q.size() < 3) begin
      failures++;
      $display("FAIL b2b_done_count actual=%0d expected=3", done_q.size());
    end else begin
      checks++; if (done_q[1] - done_q[0] != FRAME) begin failures++; $display("FAIL b2b_spacing01 actual=%0d expected=%0d", done_q[1] - done_q[0], FRAME); end
      checks++; if (done_q[2] - done_q[1] != FRAME) begin failures++; $display("FAIL b2b_spacing12 actual=%0d expected=%0d", done_q[2] - done_q[1], FRAME); end
      checks++; if (start_q[1] != done_q[0]) begin failures++; $display("FAIL b2b_gap1 actual=%0d expected=%0d", start_q[1], done_q[0]); end
      checks++; if (start_q[2] != done_q[1]) begin failures++; $display("FAIL b2b_gap2 actual=%0d expected=%0d", start_q[2], done_q[1]); end
    end
    wait_drain("b2b", 2 * FRAME);
  endtask

  task automatic test_fill_overflow;
    wr(8'hEE, 1);
    step(1);
    checks++; if (tx_busy_out !== 1'b1 || level_out !== 5'd0) begin failures++; $display("FAIL fill_setup actual=%b/%0d expected=1/0", tx_busy_out, level_out); end
    for (int i = 0; i < 17; i++) begin
      wr(8'(i), i < 16);
      if (i == 15) begin
        checks++; if (level_out !== 5'd16) begin failures++; $display("FAIL fill_level16 actual=%0d expected=16", level_out); end
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL fill_full actual=%b expected=1", full_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL fill_no_overflow actual=%b expected=0", overflow_out); end
      end
    end
    checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL fill_overflow actual=%b expected=1", overflow_out); end
    checks++; if (level_out !== 5'd16) begin failures++; $display("FAIL fill_level_after actual=%0d expected=16", level_out); end
    wait_drain("fill", 18 * FRAME);
    checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL fill_overflow_sticky actual=%b expected=1", overflow_out); end
  endtask

  task automatic test_simul_write_pop;
    int k0;
    k0 = cyc;
    wr(8'hA1, 1);
    wr(8'hB2, 1);
    wr(8'hC3, 1);
    wr(8'hD4, 1);
    while (cyc < k0 + 1 + FRAME) step(1);
    checks++; if (level_out !== 5'd3) begin failures++; $display("FAIL simul_level_before actual=%0d expected=3", level_out); end
    wr(8'hE5, 1);
    checks++; if (tx_done_out !== 1'b1) begin failures++; $display("FAIL simul_pop_edge actual=%b expected=1", tx_done_out); end
    checks++; if (level_out !== 5'd3) begin failures++; $display("FAIL simul_level_after actual=%0d expected=3", level_out); end
    wait_drain("simul", 6 * FRAME);
  endtask

  task automatic test_wrap;
    int rx0;
    rx0 = rx_count;
    for (int i = 0; i < 40; i++) begin
      wr(8'h40 + 8'(i), 1);
      step(59);
    end
    wait_drain("wrap", 50 * FRAME);
    checks++; if (rx_count - rx0 != 40) begin failures++; $display("FAIL wrap_frames actual=%0d expected=40", rx_count - rx0); end
  endtask

  task automatic test_reset_mid;
    int k0;
    k0 = cyc;
    wr(8'hFF, 1);
    step(1);
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1);
    while (cyc < k0 + 2 + 4 * T + 2) step(1);
    checks++; if (tx_busy_out !== 1'b1 || level_out !== 5'd5) begin failures++; $display("FAIL rmid_setup actual=%b/%0d expected=1/5", tx_busy_out, level_out); end
    #2;
    rst_in = 1'b1;
    exp_q.delete();
    #1;
    checks++; if (tx_serial_out !== 1'b1) begin failures++; $display("FAIL rmid_line actual=%b expected=1", tx_serial_out); end
    checks++; if (level_out !== 5'd0) begin failures++; $display("FAIL rmid_level actual=%0d expected=0", level_out); end
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL rmid_empty actual=%b expected=1", empty_out); end
    checks++; if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL rmid_busy actual=%b expected=0", tx_busy_out); end
    checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL rmid_overflow actual=%b expected=0", overflow_out); end
    step(2);
    rst_in = 1'b0;
    done_q.delete();
    start_q.delete();
    step(3 * FRAME);
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL rmid_spurious_done actual=%0d expected=0", done_q.size()); end
    checks++; if (start_q.size() != 0) begin failures++; $display("FAIL rmid_spurious_frame actual=%0d expected=0", start_q.size()); end
    checks++; if (tx_serial_out !== 1'b1) begin failures++; $display("FAIL rmid_idle_line actual=%b expected=1", tx_serial_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_simul_write_pop();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d expected<2000000", $time);
    $fatal(1, "global timeout");
  end

endmodule
